// File: rtl/xadc_multi_monitor_pkg.sv
// Shared definitions for the XADC multi-channel monitor: FSM state
// encoding, DRP timeout length, code width and channel limit.
package xadc_mon_pkg;

    localparam int CODE_W      = 12;
    localparam int MAX_CH      = 8;
    localparam int DRP_TIMEOUT = 255;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_ACC  = 3'd3;
    localparam logic [2:0] ST_EMIT = 3'd4;

    typedef logic [CODE_W-1:0] code_t;

    function automatic code_t code_min(input code_t a, input code_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic code_t code_max(input code_t a, input code_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/xadc_multi_monitor_if.sv
// DRP read port plus averaged-result stream of the XADC monitor.
// master = monitor side, slave = XADC/consumer side.
interface xadc_multi_monitor_if;
    import xadc_mon_pkg::*;

    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_do;
    logic        drp_drdy;

    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_ch;
    code_t       res_code;
    code_t       res_min;
    code_t       res_max;

    modport master (
        output drp_den, drp_daddr,
        input  drp_do, drp_drdy,
        output res_valid, res_ch, res_code, res_min, res_max,
        input  res_ready
    );

    modport slave (
        input  drp_den, drp_daddr,
        output drp_do, drp_drdy,
        input  res_valid, res_ch, res_code, res_min, res_max,
        output res_ready
    );

endinterface

// File: rtl/xadc_multi_monitor_alarm_hyst.sv
// Per-channel alarm with hysteresis: sets at/above ALARM_HI, clears
// below ALARM_LO, holds in between. Evaluated only when i_en is high.
module xadc_alarm_hyst
    import xadc_mon_pkg::*;
#(
    parameter code_t ALARM_HI = 12'hB6A,
    parameter code_t ALARM_LO = 12'hB20
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  code_t i_code,
    output logic  o_alarm
);

    logic r_alarm;

    // Hysteresis level update on each accepted result for this channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alarm <= 1'b0;
        end else if (i_en) begin
            if (i_code >= ALARM_HI) begin
                r_alarm <= 1'b1;
            end else if (i_code < ALARM_LO) begin
                r_alarm <= 1'b0;
            end
        end
    end

    assign o_alarm = r_alarm;

endmodule

// File: rtl/xadc_multi_monitor.sv
// XADC multi-channel monitor: polls NUM_CH DRP channels every POLL_DIV
// cycles, averages 2^AVG_LOG2 sweeps per channel and streams the
// results with per-channel hysteresis alarms.
// Optional feature: define XADC_MINMAX_EN for per-channel running
// min/max on res_min/res_max (otherwise both are constant 0).
//
//   state   | meaning
//   IDLE    | waiting for a pending sweep request
//   REQ     | one-cycle DRP read strobe for the current channel
//   WAIT    | waiting for drp_drdy, 255-cycle timeout
//   ACC     | add sample into channel accumulator, advance channel
//   EMIT    | present averaged results for channels 0..NUM_CH-1
module xadc_multi_monitor
    import xadc_mon_pkg::*;
#(
    parameter int    NUM_CH   = 4,
    parameter int    AVG_LOG2 = 2,
    parameter int    POLL_DIV = 100_000,
    parameter code_t ALARM_HI = 12'hB6A,
    parameter code_t ALARM_LO = 12'hB20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7*NUM_CH-1:0]   ch_addr,
    xadc_multi_monitor_if.master  bus,
    output logic [NUM_CH-1:0]     alarm,
    output logic                  timeout_err
);

    localparam int         ACC_W      = CODE_W + AVG_LOG2;
    localparam int         POLL_W     = $clog2(POLL_DIV);
    localparam int         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [2:0] LAST_CH    = 3'(NUM_CH - 1);
    localparam logic [4:0] LAST_SWEEP = 5'((1 << AVG_LOG2) - 1);
    localparam logic [7:0] TO_LAST    = 8'(DRP_TIMEOUT - 1);

    logic [2:0]          r_state;
    logic [POLL_W-1:0]   r_poll_cnt;
    logic                r_pend;
    logic [2:0]          r_ch;
    logic [4:0]          r_sweep;
    logic [7:0]          r_to_cnt;
    logic [7*NUM_CH-1:0] r_addr;
    code_t               r_sample;
    code_t               r_last [NUM_CH];
    logic [ACC_W-1:0]    r_acc  [NUM_CH];
    logic                r_timeout;

    logic [CH_W-1:0]     w_ch_idx;
    logic                w_poll_wrap;
    logic                w_accept;
    code_t               w_code;
    logic                w_unused_lsb;

    assign w_ch_idx     = r_ch[CH_W-1:0];
    assign w_poll_wrap  = (r_poll_cnt == POLL_W'(POLL_DIV - 1));
    assign w_accept     = (r_state == ST_EMIT) && bus.res_ready;
    assign w_code       = code_t'(r_acc[w_ch_idx] >> AVG_LOG2);
    assign w_unused_lsb = ^bus.drp_do[3:0];

    // Poll timer, single-deep request latch and the sweep/average FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_poll_cnt <= '0;
            r_pend     <= 1'b0;
            r_ch       <= '0;
            r_sweep    <= '0;
            r_to_cnt   <= '0;
            r_addr     <= '0;
            r_sample   <= '0;
            r_timeout  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_last[k] <= '0;
                r_acc[k]  <= '0;
            end
        end else begin
            r_poll_cnt <= w_poll_wrap ? '0 : r_poll_cnt + 1'b1;
            if (w_poll_wrap) begin
                r_pend <= 1'b1;
            end else if (r_state == ST_IDLE && r_pend) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_pend) begin
                        r_state <= ST_REQ;
                        r_ch    <= '0;
                        r_addr  <= ch_addr;
                    end
                end
                ST_REQ: begin
                    r_state  <= ST_WAIT;
                    r_to_cnt <= '0;
                end
                ST_WAIT: begin
                    if (bus.drp_drdy) begin
                        r_sample         <= bus.drp_do[15:4];
                        r_last[w_ch_idx] <= bus.drp_do[15:4];
                        r_state          <= ST_ACC;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_sample  <= r_last[w_ch_idx];
                        r_timeout <= 1'b1;
                        r_state   <= ST_ACC;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                ST_ACC: begin
                    r_acc[w_ch_idx] <= r_acc[w_ch_idx] + ACC_W'(r_sample);
                    if (r_ch == LAST_CH) begin
                        r_ch <= '0;
                        if (r_sweep == LAST_SWEEP) begin
                            r_sweep <= '0;
                            r_state <= ST_EMIT;
                        end else begin
                            r_sweep <= r_sweep + 5'd1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_ch    <= r_ch + 3'd1;
                        r_state <= ST_REQ;
                    end
                end
                ST_EMIT: begin
                    if (bus.res_ready) begin
                        if (r_ch == LAST_CH) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                r_acc[k] <= '0;
                            end
                            r_ch    <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_ch <= r_ch + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.drp_den   = (r_state == ST_REQ);
    assign bus.drp_daddr = (r_state == ST_REQ) ? r_addr[7*r_ch +: 7] : 7'd0;
    assign bus.res_valid = (r_state == ST_EMIT);
    assign bus.res_ch    = (r_state == ST_EMIT) ? r_ch : 3'd0;
    assign bus.res_code  = (r_state == ST_EMIT) ? w_code : '0;
    assign timeout_err   = r_timeout;

`ifdef XADC_MINMAX_EN
    code_t r_min [NUM_CH];
    code_t r_max [NUM_CH];
    code_t w_min;
    code_t w_max;

    // Presented min/max already include the result currently on offer
    assign w_min = code_min(w_code, r_min[w_ch_idx]);
    assign w_max = code_max(w_code, r_max[w_ch_idx]);

    // Running min/max committed when the result is accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_min[k] <= 12'hFFF;
                r_max[k] <= 12'h000;
            end
        end else if (w_accept) begin
            r_min[w_ch_idx] <= w_min;
            r_max[w_ch_idx] <= w_max;
        end
    end

    assign bus.res_min = (r_state == ST_EMIT) ? w_min : r_min[w_ch_idx];
    assign bus.res_max = (r_state == ST_EMIT) ? w_max : r_max[w_ch_idx];
`else
    assign bus.res_min = '0;
    assign bus.res_max = '0;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_alarm
        xadc_alarm_hyst #(
            .ALARM_HI (ALARM_HI),
            .ALARM_LO (ALARM_LO)
        ) u_hyst (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_accept && (r_ch == 3'(k))),
            .i_code  (w_code),
            .o_alarm (alarm[k])
        );
    end

endmodule

// File: doc/xadc_multi_monitor.md
XADC_MULTI_MONITOR -- requirements
Module: xadc_multi_monitor

Interface
REQ-001 Parameter NUM_CH, default 4, number of polled XADC channels, legal range 1..8.
REQ-002 Parameter AVG_LOG2, default 2, averaging depth exponent; each result averages 2^AVG_LOG2 sweeps; legal range 0..4.
REQ-003 Parameter POLL_DIV, default 100_000, clk cycles between sweep starts; minimum 64.
REQ-004 Parameter ALARM_HI, default 12'hB6A, 12-bit code at or above which a channel alarm sets.
REQ-005 Parameter ALARM_LO, default 12'hB20, 12-bit code below which a channel alarm clears; ALARM_LO < ALARM_HI.
REQ-006 clk  in  1  system clock, single clock domain.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 ch_addr  in  7*NUM_CH  DRP address per channel; channel k occupies bits [7k+6:7k]; sampled at each sweep start.
REQ-009 drp_den  out  1  DRP read strobe.
REQ-010 drp_daddr  out  7  DRP address.
REQ-011 drp_do  in  16  DRP read data; the 12-bit code is drp_do[15:4].
REQ-012 drp_drdy  in  1  DRP data valid.
REQ-013 res_valid  out  1  averaged result available.
REQ-014 res_ready  in  1  consumer accepts the result.
REQ-015 res_ch  out  3  channel index of the result.
REQ-016 res_code  out  12  averaged 12-bit code.
REQ-017 res_min, res_max  out  12 each  per-channel running min/max codes (see Configuration).
REQ-018 alarm  out  NUM_CH  per-channel alarm level.
REQ-019 timeout_err  out  1  sticky DRP-timeout flag.

Function
REQ-020 The poll counter SHALL count 0..POLL_DIV-1 and wrap, issuing a sweep request on each wrap; a request raised while the FSM is not in IDLE SHALL be held pending (at most one held), never queued deeper.
REQ-021 The FSM SHALL have states IDLE, REQ, WAIT, ACC, EMIT; IDLE->REQ on a pending request; REQ->WAIT after exactly one cycle with drp_den=1 and drp_daddr=ch_addr[channel].
REQ-022 In WAIT, drp_drdy=1 SHALL capture drp_do[15:4] and move to ACC; drp_drdy outside WAIT SHALL be ignored.
REQ-023 WAIT SHALL time out after 255 cycles without drp_drdy, setting timeout_err and moving to ACC with the previous sample of that channel (0 if none).
REQ-024 ACC SHALL add the sample into a (12+AVG_LOG2)-bit per-channel accumulator, then go to REQ for the next channel, or, after channel NUM_CH-1, increment the sweep counter and go to IDLE.
REQ-025 When the sweep counter wraps at 2^AVG_LOG2, the FSM SHALL go to EMIT instead of IDLE.
REQ-026 EMIT SHALL present channels 0..NUM_CH-1 in order, res_code = accumulator >> AVG_LOG2 (truncating); a result SHALL stay stable while res_valid=1 and res_ready=0 and advance on the res_valid&res_ready cycle.
REQ-027 After the last channel is accepted, EMIT SHALL clear all accumulators and go to IDLE.
REQ-028 alarm[k] SHALL update on acceptance of channel k: set when res_code >= ALARM_HI; clear when res_code < ALARM_LO; otherwise hold.
REQ-029 Latency from the last drp_drdy of the final sweep to the first res_valid SHALL be 2 cycles.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force IDLE, with drp_den=0, drp_daddr=0, res_valid=0, res_ch=0, res_code=0, alarm=0, timeout_err=0, accumulators and counters 0, pending request cleared, res_min=12'hFFF, and res_max=0.
REQ-031 Reset asserted mid-WAIT or mid-EMIT SHALL discard the in-flight sample or result without any output pulse.

Configuration
REQ-032 Under the macro XADC_MINMAX_EN, per-channel min/max registers SHALL update with every averaged result and be driven on res_min/res_max alongside each result.
REQ-033 Without XADC_MINMAX_EN, res_min and res_max SHALL be constant 0 and no min/max registers SHALL exist.

Structure
REQ-034 Shared package xadc_mon_pkg SHALL hold the FSM state encoding, the 255-cycle timeout constant, the 12-bit code width, and the maximum channel count of 8.
REQ-035 The hysteresis comparator SHALL be the sub-module xadc_alarm_hyst, with one instance per channel.

Verification
REQ-036 NUM_CH=2, AVG_LOG2=0, drp_do=16'hB6A0 on both channels -> two results with res_code=12'hB6A, alarm=2'b11.
REQ-037 AVG_LOG2=2, channel-0 samples 100, 101, 102, 105 -> res_code=102 (truncating average).
REQ-038 res_ready held 0 for 50 cycles during EMIT -> res_ch and res_code stable throughout, no result lost.
REQ-039 drp_drdy withheld on channel 1 -> timeout_err=1 at cycle 255 of WAIT, and the sweep completes.
REQ-040 Alarm set at 12'hB6A; next result 12'hB40 -> alarm stays 1; next result 12'hB10 -> alarm becomes 0.
REQ-041 rst_n=0 during WAIT -> next cycle drp_den=0, res_valid=0, and the FSM is in IDLE; with XADC_MINMAX_EN, res_min=12'hFFF.
